eaglesong_squeeze_seq: RTL and testbench
========================================

# eaglesong_squeeze_seq

Sequential squeeze stage of the Eaglesong hash core. It accepts the 8 rate words of a permuted state and serialises them into a digest byte stream of programmable length. When more than 32 bytes are requested, it hands the held state back to the permutation engine for another pass. It sits downstream of the permutation rounds that consume `eaglesong_absorb_comb` output, on the opposite (output) end of the sponge.

## Interface
Parameters:
- `MAX_LEN_W`, default 8: width of the output-length field. The maximum digest is 2^MAX_LEN_W − 1 bytes.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: begin a squeeze. Sampled only in IDLE.
- `output_length_bytes` in MAX_LEN_W: digest length, 1..2^MAX_LEN_W−1. Captured on `start`. A value of 0 is treated as 1.
- `state_in[7:0]` in 32 each: rate words of the permuted state.
- `state_valid` in 1: `state_in` is valid.
- `state_ready` out 1: block accepts `state_in` this cycle.
- `perm_req` out 1: one-cycle pulse requesting another permutation of `state_out`.
- `state_out[7:0]` out 32 each: held rate words, returned to the permutation engine.
- `out_byte` out 8: digest byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream consumer accepts `out_byte`.
- `out_last` out 1: the current byte is the final digest byte.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT_STATE, EMIT, PERM.
- IDLE:
  - On `start`, capture `output_length_bytes` into `remaining`, clear `byte_idx`, and go to WAIT_STATE.
- WAIT_STATE:
  - `state_ready` = 1.
  - On `state_valid`, register all 8 words into `held` and go to EMIT.
- EMIT:
  - `out_valid` = 1.
  - `out_byte = held[byte_idx[4:2]][8*byte_idx[1:0] +: 8]`, i.e. byte k of word j is bits [8k+7:8k].
  - On each `out_valid && out_ready`:
    - `remaining` decrements and `byte_idx` increments, wrapping 31 → 0.
    - If `remaining` == 1, assert `out_last` with that byte and go to IDLE.
    - Otherwise, if `byte_idx` == 31, go to PERM.
  - While `out_ready` = 0, `out_byte` and `out_last` stay stable.
- PERM:
  - Drive `perm_req` = 1 for exactly one cycle, then go to WAIT_STATE.
- `state_out` always equals `held`.
- `start` received outside IDLE is ignored.
- `state_valid` received outside WAIT_STATE is ignored, and `held` is not changed.
- Asynchronous reset mid-operation aborts the squeeze. The partial digest is discarded, and no `out_last` is produced for it.

## Timing
- Reset values:
  - State = IDLE.
  - `state_ready`, `perm_req`, `out_valid`, `out_last`, `busy` = 0.
  - `out_byte` = 0.
  - `held`, `state_out` = 0.
  - `remaining`, `byte_idx` = 0.
- Latencies:
  - `start` → `state_ready` high: 1 cycle.
  - State handshake → first `out_valid`: 1 cycle.
- Steady-state throughput is 1 byte per cycle with `out_ready` held high.
- With continuous ready, a 32-byte block takes 32 cycles.
- Block boundary cost: 1 PERM cycle, then WAIT_STATE lasts at least 1 cycle.
- On the final byte handshake, `busy` falls the next cycle. `start` is accepted again on that same cycle.
- Total bytes emitted always equals the captured length exactly. Under MAX_LEN_W = 8 that is at most 255 bytes, i.e. 8 blocks.

## Configuration
- `EAGLESONG_SQUEEZE_DIGEST_REG_EN` defined:
  - Adds output `digest_256` (256 bits) and `digest_valid` (1 bit).
  - The first 32 emitted bytes are accumulated little-endian into `digest_256`, with byte n at bits [8n+7:8n].
  - `digest_valid` pulses one cycle after byte 31 is emitted, or after `out_last` if that comes first. Unwritten bytes read 0.
  - Reset value of both is 0.
- Macro undefined: those ports and registers do not exist, and stream behaviour is identical.

## Structure
- Shared package `eaglesong_pkg` holds:
  - `RATE_WORDS` = 8, `RATE_BYTES` = 32.
  - The `eaglesong_rate_t` typedef (8 × 32-bit words).
  - The `squeeze_state_e` FSM enum.
  - `DELIM_BYTE` = 8'h06, shared with absorb.
- One sub-module, `eaglesong_byte_select`: combinational mux taking `held` and a 5-bit index and producing `out_byte`.

## Test plan
- Length 32, `held` words j = 32'h03020100 + j·32'h04040404, `out_ready` constantly 1 → bytes 00..1F in 32 consecutive cycles; `out_last` on 1F; `perm_req` never asserted.
- Length 5 → bytes 00,01,02,03,04; `out_last` on 04; FSM in IDLE the next cycle.
- Length 40 → 32 bytes, then one `perm_req` pulse; second state supplied with word0 = 32'hDDCCBBAA, word1 = 32'h44332211 → bytes AA,BB,CC,DD,11,22,33,44; `out_last` on 44.
- `out_ready` toggled 1,0,0,1 during length 4 → `out_byte` held stable while ready is low; exactly 4 transfers.
- Assert `rst_n` = 0 after byte 10 of a length-32 squeeze → all outputs go to reset values immediately; a new `start` with length 1 yields exactly one byte with `out_last`.
- With `EAGLESONG_SQUEEZE_DIGEST_REG_EN`, length 32 using the first vector → `digest_256` = 256'h1F1E…0100 and `digest_valid` pulses once.

Source files
------------

// File: rtl/eaglesong_pkg.sv
// Shared Eaglesong types and constants used by the absorb and squeeze stages.
package eaglesong_pkg;

  localparam int unsigned RATE_WORDS = 8;
  localparam int unsigned RATE_BYTES = 32;
  localparam logic [7:0]  DELIM_BYTE = 8'h06;

  typedef logic [RATE_WORDS-1:0][31:0] eaglesong_rate_t;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_WAIT_STATE,
    SQ_EMIT,
    SQ_PERM
  } squeeze_state_e;

endpackage

// File: rtl/eaglesong_byte_select.sv
// Picks byte idx[1:0] of rate word idx[4:2] from the held rate state.
module eaglesong_byte_select
  import eaglesong_pkg::*;
(
  input  eaglesong_rate_t held,
  input  logic [4:0]      idx,
  output logic [7:0]      out_byte
);

  always_comb begin
    out_byte = held[idx[4:2]][{idx[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/eaglesong_squeeze_seq.sv
// Eaglesong squeeze stage: serialises held rate words into a digest byte stream.
// Optional EAGLESONG_SQUEEZE_DIGEST_REG_EN adds a 256-bit first-block digest register.
module eaglesong_squeeze_seq
  import eaglesong_pkg::*;
#(
  parameter int unsigned MAX_LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MAX_LEN_W-1:0] output_length_bytes,
  input  eaglesong_rate_t      state_in,
  input  logic                 state_valid,
  output logic                 state_ready,
  output logic                 perm_req,
  output eaglesong_rate_t      state_out,
  output logic [7:0]           out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  ,
  output logic [255:0]         digest_256,
  output logic                 digest_valid
`endif
);

  squeeze_state_e       state, state_nxt;
  eaglesong_rate_t      held;
  logic [MAX_LEN_W-1:0] remaining;
  logic [4:0]           byte_idx;
  logic                 xfer;
  logic                 final_byte;

  assign state_out  = held;
  assign xfer       = out_valid && out_ready;
  assign final_byte = (remaining == MAX_LEN_W'(1));

  eaglesong_byte_select u_byte_select (
    .held     (held),
    .idx      (byte_idx),
    .out_byte (out_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    state_ready = 1'b0;
    perm_req    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = (state != SQ_IDLE);
    case (state)
      SQ_IDLE: begin
        if (start) state_nxt = SQ_WAIT_STATE;
      end
      SQ_WAIT_STATE: begin
        state_ready = 1'b1;
        if (state_valid) state_nxt = SQ_EMIT;
      end
      SQ_EMIT: begin
        out_valid = 1'b1;
        out_last  = final_byte;
        if (out_ready) begin
          if (final_byte) begin
            state_nxt = SQ_IDLE;
          end else if (byte_idx == 5'(RATE_BYTES - 1)) begin
            state_nxt = SQ_PERM;
          end
        end
      end
      SQ_PERM: begin
        perm_req  = 1'b1;
        state_nxt = SQ_WAIT_STATE;
      end
      default: state_nxt = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held      <= '0;
      remaining <= '0;
      byte_idx  <= '0;
    end else begin
      // A zero length request is promoted to a single byte
      if ((state == SQ_IDLE) && start) begin
        remaining <= (output_length_bytes == '0) ? MAX_LEN_W'(1) : output_length_bytes;
        byte_idx  <= '0;
      end
      if (state_ready && state_valid) begin
        held <= state_in;
      end
      if (xfer) begin
        remaining <= remaining - MAX_LEN_W'(1);
        byte_idx  <= byte_idx + 5'd1;
      end
    end
  end

`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  logic first_blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_256   <= '0;
      digest_valid <= 1'b0;
      first_blk    <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      if ((state == SQ_IDLE) && start) begin
        digest_256 <= '0;
        first_blk  <= 1'b1;
      end
      if (xfer && first_blk) begin
        digest_256[{byte_idx, 3'b000} +: 8] <= out_byte;
        if ((byte_idx == 5'(RATE_BYTES - 1)) || final_byte) begin
          first_blk    <= 1'b0;
          digest_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_eaglesong_squeeze_seq.sv
// Directed, table-driven bench for the Eaglesong squeeze stage.
module tb_eaglesong_squeeze_seq;
  import eaglesong_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      output_length_bytes = '0;
  eaglesong_rate_t state_in = '0;
  logic            state_valid = 1'b0;
  logic            state_ready;
  logic            perm_req;
  eaglesong_rate_t state_out;
  logic [7:0]      out_byte;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic            busy;
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  logic [255:0]    digest_256;
  logic            digest_valid;
  int              dv_cnt = 0;
`endif

  eaglesong_squeeze_seq #(.MAX_LEN_W(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .output_length_bytes (output_length_bytes),
    .state_in            (state_in),
    .state_valid         (state_valid),
    .state_ready         (state_ready),
    .perm_req            (perm_req),
    .state_out           (state_out),
    .out_byte            (out_byte),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_last            (out_last),
    .busy                (busy)
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
    ,
    .digest_256          (digest_256),
    .digest_valid        (digest_valid)
`endif
  );

  always #5 clk = ~clk;

`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
  always @(negedge clk) if (digest_valid) dv_cnt++;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Block b carries stream bytes 32*b .. 32*b+31 (mod 256), little-endian within words
  function automatic eaglesong_rate_t pattern(input int blk);
    eaglesong_rate_t r;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 4; k++)
        r[j][8*k +: 8] = 8'((32*blk + 4*j + k) % 256);
    return r;
  endfunction

  eaglesong_rate_t alt_state;
  logic [7:0]      alt_exp [8];

  typedef struct {
    int len;
    int exp_n;
    int exp_perm;
    bit alt;
  } case_t;

  case_t cases [8];

  task automatic run_case(input int len, input int exp_n, input int exp_perm, input bit alt);
    int  got, perms, blk, cyc, first_cyc, last_cyc;
    bit  done;
    logic [7:0] eb;
    got = 0; perms = 0; blk = 0; cyc = 0; first_cyc = 0; last_cyc = 0; done = 0;
    @(negedge clk);
    start = 1'b1;
    output_length_bytes = 8'(len);
    state_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 256'(busy), 256'(1));
    chk("start_ready_latency", 256'(state_ready), 256'(1));
    while (!done && cyc < 3000) begin
      if (perm_req) begin
        perms++;
        chk("perm_state_out", state_out, pattern(blk - 1));
      end
      if (out_valid && out_ready) begin
        eb = 8'(got);
        if (alt && got >= 32) eb = alt_exp[got - 32];
        chk("byte", 256'(out_byte), 256'(eb));
        chk("last", 256'(out_last), 256'(got == exp_n - 1));
        if (got == 0) first_cyc = cyc;
        got++;
        if (out_last) begin
          done = 1;
          last_cyc = cyc;
        end
      end
      // Junk offered outside WAIT_STATE must never reach the held state
      if (state_ready) begin
        state_in = (alt && blk == 1) ? alt_state : pattern(blk);
        blk++;
      end else begin
        state_in = '1;
      end
      state_valid = 1'b1;
      @(negedge clk);
      cyc++;
    end
    state_valid = 1'b0;
    chk("completed", 256'(done), 256'(1));
    chk("byte_count", 256'(got), 256'(exp_n));
    chk("perm_count", 256'(perms), 256'(exp_perm));
    chk("span_cycles", 256'(last_cyc - first_cyc), 256'(exp_n - 1 + 2*exp_perm));
    chk("busy_after_last", 256'(busy), 256'(0));
    chk("valid_after_last", 256'(out_valid), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic       rdy_seq  [6];
  logic [7:0] byte_seq [6];
  logic       last_seq [6];
  int         xfers;

  initial begin
    alt_state    = '0;
    alt_state[0] = 32'hDDCCBBAA;
    alt_state[1] = 32'h44332211;
    alt_exp  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    cases = '{
      '{32, 32, 0, 1'b0},
      '{5, 5, 0, 1'b0},
      '{40, 40, 1, 1'b1},
      '{0, 1, 0, 1'b0},
      '{1, 1, 0, 1'b0},
      '{33, 33, 1, 1'b0},
      '{64, 64, 1, 1'b0},
      '{255, 255, 7, 1'b0}
    };
    rdy_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    byte_seq = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03};
    last_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(state_ready), 256'(0));
    chk("rst_perm", 256'(perm_req), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_last", 256'(out_last), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_byte", 256'(out_byte), 256'(0));
    chk("rst_state_out", state_out, 256'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_case(cases[i].len, cases[i].exp_n, cases[i].exp_perm, cases[i].alt);
`ifdef EAGLESONG_SQUEEZE_DIGEST_REG_EN
      if (i == 0) begin
        @(negedge clk);
        chk("digest_value", digest_256, pattern(0));
        chk("digest_pulses", 256'(dv_cnt), 256'(1));
      end
`endif
    end

    // Back-pressure: ready 1,0,0,1,... with a stray start that must be ignored
    @(negedge clk);
    start = 1'b1;
    output_length_bytes = 8'd4;
    @(negedge clk);
    start = 1'b0;
    state_in = pattern(0);
    state_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    state_valid = 1'b0;
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy_seq[i];
      start = (i >= 1 && i <= 3);
      output_length_bytes = (i >= 1 && i <= 3) ? 8'd200 : 8'd4;
      chk("bp_valid", 256'(out_valid), 256'(1));
      chk("bp_byte", 256'(out_byte), 256'(byte_seq[i]));
      chk("bp_last", 256'(out_last), 256'(last_seq[i]));
      if (out_valid && out_ready) xfers++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("bp_xfers", 256'(xfers), 256'(4));
    chk("bp_idle", 256'(busy), 256'(0));

    // Reset in the middle of a 32-byte squeeze
    @(negedge clk);
    start = 1'b1;
    output_length_bytes = 8'd32;
    @(negedge clk);
    start = 1'b0;
    state_in = pattern(0);
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_abort_byte", 256'(out_byte), 256'(11));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 256'(out_valid), 256'(0));
    chk("abort_last", 256'(out_last), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_byte", 256'(out_byte), 256'(0));
    chk("abort_ready", 256'(state_ready), 256'(0));
    chk("abort_state_out", state_out, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_case(1, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
